// File: rtl/breathing_engine_if.sv
// Pixel beat stream from the effect generator to the serial LED band driver.
// Valid/ready handshake; master holds data/addr/last stable while valid && !ready.
interface breathing_engine_if #(
  parameter int ADDR_W = 6
);
  logic              pix_valid;
  logic              pix_ready;
  logic [23:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_last;

  modport master (output pix_valid, pix_data, pix_addr, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_addr, pix_last, output pix_ready);
endinterface

// File: rtl/breathing_engine.sv
// LED breathing/wave effect generator: one GRB beat per cycle, frame gap between frames.
// First beat one cycle after entering STREAM; beats stall on !pix_ready. Optional BREATH_GAMMA_EN.
module breathing_engine #(
  parameter int NUM_LEDS  = 60,
  parameter int ADDR_W    = 6,
  parameter int PHASE_W   = 9,
  parameter int SPREAD    = 8,
  parameter int FRAME_GAP = 3000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  breathing_engine_if.master pix,
  output logic               frame_done,
  output logic [2:0]         color_idx,
  output logic [PHASE_W-1:0] phase
);
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_WAVE    = 2'd1;
  localparam logic [1:0] MODE_SOLID   = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  typedef enum logic [1:0] {IDLE, GAP, STREAM} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               pix_valid_q, pix_valid_d;
  logic [23:0]        pix_data_q, pix_data_d;
  logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
  logic               pix_last_q, pix_last_d;
  logic               frame_done_q, frame_done_d;
  logic [2:0]         color_idx_q, color_idx_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  logic [ADDR_W-1:0]  next_addr;
  logic [PHASE_W-1:0] p_eff;
  logic [PHASE_W-2:0] tri_val;
  logic [7:0]         bright;
  logic [7:0]         b_eff;
  logic [8:0]         k;
  logic [23:0]        pal;
  logic [23:0]        pix_calc;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] m);
    return 8'((17'(c) * 17'(m)) >> 8);
  endfunction

  // Pixel for the beat about to be loaded: addr 0 at frame start, else the successor.
  always_comb begin
    next_addr = pix_valid_q ? pix_addr_q + ADDR_W'(1) : '0;
    p_eff     = phase_q;
    if (mode_q == MODE_WAVE)
      p_eff = phase_q + PHASE_W'(32'(next_addr) * 32'(SPREAD));
    tri_val = p_eff[PHASE_W-1] ? ~p_eff[PHASE_W-2:0] : p_eff[PHASE_W-2:0];
    bright  = 8'(tri_val >> (PHASE_W - 9));
`ifdef BREATH_GAMMA_EN
    b_eff = 8'((17'(bright) * 17'({1'b0, bright} + 9'd1)) >> 8);
`else
    b_eff = bright;
`endif
    if (mode_q == MODE_SOLID)
      b_eff = 8'hFF;
    k = {1'b0, b_eff} + 9'd1;
    case (color_idx_q)
      3'd0:    pal = 24'h00FF00;
      3'd1:    pal = 24'hFF0000;
      3'd2:    pal = 24'h0000FF;
      3'd3:    pal = 24'hFFFF00;
      3'd4:    pal = 24'hFF00FF;
      3'd5:    pal = 24'h00FFFF;
      3'd6:    pal = 24'hFFFFFF;
      default: pal = 24'h80FF00;
    endcase
    pix_calc = '0;
    if (mode_q != MODE_OFF)
      pix_calc = {scale(pal[23:16], k), scale(pal[15:8], k), scale(pal[7:0], k)};
  end

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    mode_d       = mode_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_last_d   = pix_last_q;
    frame_done_d = 1'b0;
    color_idx_d  = color_idx_q;
    phase_d      = phase_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(FRAME_GAP - 1)) begin
          gap_cnt_d = '0;
          if (enable) begin
            state_d = STREAM;
            mode_d  = mode;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      STREAM: begin
        if (!pix_valid_q || pix.pix_ready) begin
          if (pix_valid_q && pix_last_q) begin
            pix_valid_d  = 1'b0;
            pix_last_d   = 1'b0;
            state_d      = GAP;
            frame_done_d = 1'b1;
            phase_d      = phase_q + PHASE_W'(1);
            if ((&phase_q) && (mode_q == MODE_BREATHE || mode_q == MODE_WAVE))
              color_idx_d = color_idx_q + 3'd1;
          end else begin
            pix_valid_d = 1'b1;
            pix_addr_d  = next_addr;
            pix_last_d  = (next_addr == ADDR_W'(NUM_LEDS - 1));
            pix_data_d  = pix_calc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      mode_q       <= MODE_BREATHE;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      color_idx_q  <= '0;
      phase_q      <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      mode_q       <= mode_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_last_q   <= pix_last_d;
      frame_done_q <= frame_done_d;
      color_idx_q  <= color_idx_d;
      phase_q      <= phase_d;
    end
  end

  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_addr  = pix_addr_q;
  assign pix.pix_last  = pix_last_q;
  assign frame_done    = frame_done_q;
  assign color_idx     = color_idx_q;
  assign phase         = phase_q;
endmodule

// File: tb/tb_breathing_engine.sv
// Directed bench for breathing_engine with a 4-LED strip and a 4-cycle frame gap.
module tb_breathing_engine;
  localparam int NUM_LEDS  = 4;
  localparam int ADDR_W    = 6;
  localparam int PHASE_W   = 9;
  localparam int SPREAD    = 8;
  localparam int FRAME_GAP = 4;

`ifdef BREATH_GAMMA_EN
  localparam logic [23:0] W1 = 24'h000000, W2 = 24'h000100, W3 = 24'h000200;
  localparam logic [23:0] B128 = 24'h004000, B129 = 24'h004100, B259 = 24'hF90000;
`else
  localparam logic [23:0] W1 = 24'h000800, W2 = 24'h001000, W3 = 24'h001800;
  localparam logic [23:0] B128 = 24'h008000, B129 = 24'h008100, B259 = 24'hFC0000;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               frame_done;
  logic [2:0]         color_idx;
  logic [PHASE_W-1:0] phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [23:0] bd [8];
  int          ba [8];
  logic        bl [8];
  int          nb;
  logic        done_after, valid_after, frozen_ok, got_last, valid_seen;
  int          done_cyc, prev_cyc;

  breathing_engine_if #(.ADDR_W(ADDR_W)) pix_if();

  breathing_engine #(
    .NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W),
    .SPREAD(SPREAD), .FRAME_GAP(FRAME_GAP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .pix(pix_if),
    .frame_done(frame_done), .color_idx(color_idx), .phase(phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Collects one frame at negedges; optionally stalls 5 cycles or drops enable at an address.
  task automatic get_frame(input int stall_addr, input int drop_addr);
    int guard;
    bit stalled;
    logic [ADDR_W-1:0] s_addr;
    logic [23:0] s_data;
    logic s_last;
    nb = 0; guard = 0; stalled = 0; frozen_ok = 1'b1; got_last = 1'b0;
    while (!pix_if.pix_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    while (!got_last && guard < 200) begin
      if (pix_if.pix_valid) begin
        if (!stalled && int'(pix_if.pix_addr) == stall_addr) begin
          stalled = 1;
          s_addr = pix_if.pix_addr; s_data = pix_if.pix_data; s_last = pix_if.pix_last;
          pix_if.pix_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (!pix_if.pix_valid || pix_if.pix_addr != s_addr ||
                pix_if.pix_data != s_data || pix_if.pix_last != s_last)
              frozen_ok = 1'b0;
          end
          pix_if.pix_ready = 1'b1;
        end
        if (int'(pix_if.pix_addr) == drop_addr) enable = 1'b0;
        if (nb < 8) begin
          bd[nb] = pix_if.pix_data;
          ba[nb] = int'(pix_if.pix_addr);
          bl[nb] = pix_if.pix_last;
        end
        nb++;
        got_last = pix_if.pix_last;
      end
      @(negedge clk);
      guard++;
    end
    done_after  = frame_done;
    valid_after = pix_if.pix_valid;
    done_cyc    = cyc;
    if (!got_last) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] exp_d [4];
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    check({tag, "_beats"}, 32'(nb), 32'(NUM_LEDS));
    for (int i = 0; i < NUM_LEDS && i < nb; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(ba[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(bd[i]), 32'(exp_d[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(bl[i]), (i == NUM_LEDS - 1) ? 32'd1 : 32'd0);
    end
    check({tag, "_done"}, 32'(done_after), 32'd1);
    check({tag, "_vld_after"}, 32'(valid_after), 32'd0);
  endtask

  initial begin
    pix_if.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pix_if.pix_valid), 32'd0);
    check("rst_data", 32'(pix_if.pix_data), 32'd0);
    check("rst_addr", 32'(pix_if.pix_addr), 32'd0);
    check("rst_last", 32'(pix_if.pix_last), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_color", 32'(color_idx), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);

    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_no_valid", 32'(pix_if.pix_valid), 32'd0);
    end

    // Wave at phase 0, red: b = addr*8
    mode = 2'd1; enable = 1'b1;
    get_frame(-1, -1);
    check_frame("wave", 24'h000000, W1, W2, W3);
    check("wave_phase", 32'(phase), 32'd1);

    mode = 2'd0;
    repeat (127) get_frame(-1, -1);
    check("pre128_phase", 32'(phase), 32'd128);
    get_frame(-1, -1);
    check_frame("br128", B128, B128, B128, B128);
    check("br128_phase", 32'(phase), 32'd129);

    get_frame(2, -1);
    check_frame("stall", B129, B129, B129, B129);
    check("stall_frozen", 32'(frozen_ok), 32'd1);
    prev_cyc = done_cyc;

    get_frame(-1, -1);
    check("frame_period", 32'(done_cyc - prev_cyc), 32'(NUM_LEDS + FRAME_GAP + 1));

    repeat (380) get_frame(-1, -1);
    check("pre_wrap_phase", 32'(phase), 32'd511);
    check("pre_wrap_color", 32'(color_idx), 32'd0);
    get_frame(-1, -1);
    check_frame("wrap", 24'h0, 24'h0, 24'h0, 24'h0);
    check("wrap_phase", 32'(phase), 32'd0);
    check("wrap_color", 32'(color_idx), 32'd1);

    repeat (256) get_frame(-1, -1);
    check("pre256_phase", 32'(phase), 32'd256);
    get_frame(-1, -1);
    check_frame("br256", 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);

    mode = 2'd2;
    get_frame(-1, -1);
    check_frame("solid", 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);

    mode = 2'd3;
    get_frame(-1, -1);
    check_frame("off", 24'h0, 24'h0, 24'h0, 24'h0);
    check("off_phase", 32'(phase), 32'd259);

    mode = 2'd0;
    get_frame(-1, 1);
    check_frame("drop", B259, B259, B259, B259);
    valid_seen = 1'b0;
    repeat (FRAME_GAP + 8) begin
      @(negedge clk);
      if (pix_if.pix_valid) valid_seen = 1'b1;
    end
    check("drop_no_valid", 32'(valid_seen), 32'd0);
    check("drop_state_idle", 32'(dut.state_q), 32'd0);

    // Asynchronous reset in the middle of a frame
    enable = 1'b1;
    begin
      int guard = 0;
      while (!pix_if.pix_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
    end
    check("arst_pre_valid", 32'(pix_if.pix_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(pix_if.pix_valid), 32'd0);
    check("arst_phase", 32'(phase), 32'd0);
    check("arst_color", 32'(color_idx), 32'd0);
    check("arst_state", 32'(dut.state_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
